// File: rtl/traffic_phase_fsm.sv
// ============================================================================
// Module   : traffic_phase_fsm
// Purpose  : Timed four-way intersection phase sequencer with left-turn skip.
//            Optional emergency all-red preemption with TRAFFIC_EMERG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_phase_fsm #(
    parameter int TICK_DIV = 50000000,
    parameter int LEFT_T   = 5,
    parameter int GREEN_T  = 20,
    parameter int YELLOW_T = 3,
    parameter int RED_T    = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       enable,
    input  logic       leftReqNS,
    input  logic       leftReqEW,
`ifdef TRAFFIC_EMERG_EN
    input  logic       emergency,
`endif
    output logic [3:0] fsmOut,
    output logic       phaseDone
);

    localparam int             PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [3:0] {
        NS_LEFT   = 4'd0,
        NS_GREEN  = 4'd1,
        NS_YELLOW = 4'd2,
        ALL_RED_A = 4'd3,
        EW_LEFT   = 4'd4,
        EW_GREEN  = 4'd5,
        EW_YELLOW = 4'd6,
`ifdef TRAFFIC_EMERG_EN
        EMERG     = 4'd8,
`endif
        ALL_RED_B = 4'd7
    } phase_e;

    phase_e          state_q, state_d, succ_w;
    logic [PW-1:0]   presc_q, presc_d;
    logic [7:0]      timer_q, timer_d, dur_w;
    logic            done_q, done_d;
    logic            latch_ns_q, latch_ns_d;
    logic            latch_ew_q, latch_ew_d;
    logic            tick_w, req_ns_w, req_ew_w, emerg_w;

`ifdef TRAFFIC_EMERG_EN
    assign emerg_w = emergency;
`else
    assign emerg_w = 1'b0;
`endif

    assign tick_w   = enable && (presc_q == PRESC_LAST);
    assign req_ns_w = latch_ns_q | leftReqNS;
    assign req_ew_w = latch_ew_q | leftReqEW;

    always_comb begin
        dur_w = 8'd1;
        case (state_q)
            NS_LEFT,   EW_LEFT:   dur_w = 8'(LEFT_T);
            NS_GREEN,  EW_GREEN:  dur_w = 8'(GREEN_T);
            NS_YELLOW, EW_YELLOW: dur_w = 8'(YELLOW_T);
            ALL_RED_A, ALL_RED_B: dur_w = 8'(RED_T);
            default:              dur_w = 8'd1;
        endcase
    end

    // Successor when the current phase expires; the all-red hold re-selects
    // itself while emergency is asserted, which suppresses phaseDone.
    always_comb begin
        succ_w = ALL_RED_B;
        case (state_q)
            NS_LEFT:   succ_w = NS_GREEN;
            NS_GREEN:  succ_w = NS_YELLOW;
            NS_YELLOW: succ_w = emerg_w ? ALL_RED_B : ALL_RED_A;
            ALL_RED_A: succ_w = emerg_w ? ALL_RED_B : (req_ew_w ? EW_LEFT : EW_GREEN);
            EW_LEFT:   succ_w = EW_GREEN;
            EW_GREEN:  succ_w = EW_YELLOW;
            EW_YELLOW: succ_w = emerg_w ? ALL_RED_B : ALL_RED_B;
            ALL_RED_B: succ_w = emerg_w ? ALL_RED_B : (req_ns_w ? NS_LEFT : NS_GREEN);
`ifdef TRAFFIC_EMERG_EN
            EMERG:     succ_w = emergency ? EMERG : ALL_RED_B;
`endif
            default:   succ_w = ALL_RED_B;
        endcase
`ifdef TRAFFIC_EMERG_EN
        if (emergency && (state_q == NS_YELLOW || state_q == EW_YELLOW ||
                          state_q == ALL_RED_A || state_q == ALL_RED_B)) begin
            succ_w = EMERG;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        presc_d = presc_q;
        done_d  = 1'b0;
        if (enable) begin
            presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
`ifdef TRAFFIC_EMERG_EN
            if (emergency && (state_q == NS_LEFT || state_q == NS_GREEN)) begin
                state_d = NS_YELLOW;
                timer_d = 8'd0;
                done_d  = 1'b1;
            end else if (emergency && (state_q == EW_LEFT || state_q == EW_GREEN)) begin
                state_d = EW_YELLOW;
                timer_d = 8'd0;
                done_d  = 1'b1;
            end else
`endif
            if (tick_w) begin
                if (timer_q == dur_w - 8'd1) begin
                    state_d = succ_w;
                    timer_d = 8'd0;
                    done_d  = (succ_w != state_q);
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
        end
    end

    // Latches keep capturing while frozen; entering the served left phase
    // clears them and takes priority over a same-cycle request.
    always_comb begin
        latch_ns_d = latch_ns_q;
        latch_ew_d = latch_ew_q;
        if (leftReqNS && state_q != NS_LEFT) latch_ns_d = 1'b1;
        if (leftReqEW && state_q != EW_LEFT) latch_ew_d = 1'b1;
        if (state_d == NS_LEFT && state_q != NS_LEFT) latch_ns_d = 1'b0;
        if (state_d == EW_LEFT && state_q != EW_LEFT) latch_ew_d = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ALL_RED_B;
            presc_q    <= '0;
            timer_q    <= 8'd0;
            done_q     <= 1'b0;
            latch_ns_q <= 1'b0;
            latch_ew_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            timer_q    <= timer_d;
            done_q     <= done_d;
            latch_ns_q <= latch_ns_d;
            latch_ew_q <= latch_ew_d;
        end
    end

    assign fsmOut    = state_q;
    assign phaseDone = done_q;

endmodule

`default_nettype wire

// File: tb/tb_traffic_phase_fsm.sv
// ============================================================================
// Module   : tb_traffic_phase_fsm
// Purpose  : Scoreboard bench for traffic_phase_fsm (phase codes and lengths).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_traffic_phase_fsm;

    localparam int TD = 2;
    localparam int LT = 1;
    localparam int GT = 3;
    localparam int YT = 2;
    localparam int RT = 1;
    localparam int L_LEFT  = LT * TD;
    localparam int L_GREEN = GT * TD;
    localparam int L_YEL   = YT * TD;
    localparam int L_RED   = RT * TD;

    logic       clk       = 1'b0;
    logic       resetn    = 1'b1;
    logic       enable    = 1'b1;
    logic       leftReqNS = 1'b0;
    logic       leftReqEW = 1'b0;
`ifdef TRAFFIC_EMERG_EN
    logic       emergency = 1'b0;
`endif
    logic [3:0] fsmOut;
    logic       phaseDone;

    traffic_phase_fsm #(
        .TICK_DIV (TD),
        .LEFT_T   (LT),
        .GREEN_T  (GT),
        .YELLOW_T (YT),
        .RED_T    (RT)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .enable    (enable),
        .leftReqNS (leftReqNS),
        .leftReqEW (leftReqEW),
`ifdef TRAFFIC_EMERG_EN
        .emergency (emergency),
`endif
        .fsmOut    (fsmOut),
        .phaseDone (phaseDone)
    );

    always #5 clk = ~clk;

    typedef struct {
        int code;
        int len;
    } exp_t;

    exp_t sb[$];
    int   n_vec     = 0;
    int   n_err     = 0;
    int   prev_code = 7;
    int   cur_len   = 0;

    task automatic chk_eq(input string tag, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Expected next phase code plus the length (cycles) of the phase it replaces.
    task automatic push(input int code, input int len);
        exp_t e;
        e.code = code;
        e.len  = len;
        sb.push_back(e);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk_eq(tag, sb.size(), 0);
        sb.delete();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!resetn) begin
            prev_code = 7;
            cur_len   = 0;
        end else if (int'(fsmOut) != prev_code) begin
            chk_eq("phaseDone_on_change", int'(phaseDone), 1);
            if (sb.size() == 0) begin
                chk_eq("unexpected_phase", int'(fsmOut), prev_code);
            end else begin
                e = sb.pop_front();
                chk_eq("phase_code", int'(fsmOut), e.code);
                if (e.len >= 0) chk_eq("phase_len", cur_len, e.len);
            end
            prev_code = int'(fsmOut);
            cur_len   = 1;
        end else begin
            chk_eq("phaseDone_steady", int'(phaseDone), 0);
            cur_len++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 resetn = 1'b0;
        #1;
        chk_eq("reset_fsmOut", int'(fsmOut), 7);
        chk_eq("reset_phaseDone", int'(phaseDone), 0);

        // Base cycle with no requests
        push(1, L_RED); push(2, L_GREEN); push(3, L_YEL);
        push(5, L_RED); push(6, L_GREEN); push(7, L_YEL);
        @(posedge clk); #1 resetn = 1'b1;
        drain("drain_base");

        // NS left request pulsed during EW_GREEN
        push(1, L_RED); push(2, L_GREEN); push(3, L_YEL); push(5, L_RED);
        drain("drain_pre_ns_req");
        leftReqNS = 1'b1;
        @(posedge clk); #1 leftReqNS = 1'b0;
        push(6, L_GREEN); push(7, L_YEL); push(0, L_RED); push(1, L_LEFT);
        drain("drain_ns_left");

        // Freeze mid NS_GREEN for 10 cycles; next round skips NS_LEFT
        enable = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk_eq("freeze_hold", int'(fsmOut), 1);
        enable = 1'b1;
        push(2, L_GREEN + 10); push(3, L_YEL); push(5, L_RED);
        push(6, L_GREEN); push(7, L_YEL); push(1, L_RED);
        drain("drain_freeze");

        // EW request held across EW_LEFT, released after exit -> re-latched
        leftReqEW = 1'b1;
        push(2, L_GREEN); push(3, L_YEL); push(4, L_RED); push(5, L_LEFT);
        drain("drain_ew_left1");
        leftReqEW = 1'b0;
        push(6, L_GREEN); push(7, L_YEL); push(1, L_RED);
        push(2, L_GREEN); push(3, L_YEL); push(4, L_RED);
        drain("drain_ew_relatch");

        // Request arriving only during EW_LEFT is dropped
        leftReqEW = 1'b1;
        @(posedge clk); #1 leftReqEW = 1'b0;
        push(5, L_LEFT); push(6, L_GREEN); push(7, L_YEL);
        push(1, L_RED); push(2, L_GREEN); push(3, L_YEL); push(5, L_RED);
        drain("drain_ew_drop");

        // NS latch set, then async reset mid EW_YELLOW clears it
        leftReqNS = 1'b1;
        @(posedge clk); #1 leftReqNS = 1'b0;
        push(6, L_GREEN);
        drain("drain_pre_reset");
        @(posedge clk); #3 resetn = 1'b0;
        #1;
        chk_eq("async_rst_fsmOut", int'(fsmOut), 7);
        chk_eq("async_rst_phaseDone", int'(phaseDone), 0);
        push(1, L_RED); push(2, L_GREEN); push(3, L_YEL); push(5, L_RED);
        @(posedge clk); #1 resetn = 1'b1;
        drain("drain_post_reset");

`ifdef TRAFFIC_EMERG_EN
        push(6, L_GREEN); push(7, L_YEL); push(1, L_RED);
        drain("drain_pre_emerg");
        emergency = 1'b1;
        push(2, 2); push(8, L_YEL);
        drain("drain_emerg_in");
        repeat (6) @(posedge clk);
        #1;
        chk_eq("emerg_hold", int'(fsmOut), 8);
        emergency = 1'b0;
        push(7, -1); push(1, L_RED);
        drain("drain_emerg_out");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
